// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared FSM state type, counter width and helpers for key_reader
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEB_DN = 2'd1,
    HELD   = 2'd2,
    DEB_UP = 2'd3
  } key_state_t;

  localparam int CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - two-flop synchronizer for the raw pushbutton input
module key_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_reader.sv
// rtl/key_reader.sv - debounced pushbutton with press/release/long-press pulses and press counter
// Optional auto-repeat after a long press is enabled by defining KEY_AUTOREPEAT_EN.
module key_reader
  import key_pkg::*;
#(
  parameter int DEB_CYCLES    = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iKEY,
  output logic             oKEY,
  output logic             oPRESS,
  output logic             oRELEASE,
  output logic             oLONG,
  output logic [CNT_W-1:0] oCNT
);

  localparam int CW = $clog2(max3(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES)) + 1;
  // The IDLE/HELD cycle that first sees the new level counts as stable cycle one.
  localparam logic [CW-1:0] DEB_LAST = CW'((DEB_CYCLES > 2) ? (DEB_CYCLES - 2) : 0);
  localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LONG_PRE = CW'((LONG_CYCLES > 0) ? (LONG_CYCLES - 1) : 0);

  logic          ks;
  key_state_t    state, state_nxt;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] hold_cnt;
  logic          deb_done;
  logic          press_d, release_d, long_d;
  logic          rep_fire;

  key_sync u_sync (
    .clk (iCLK),
    .rst (iRST),
    .d   (iKEY),
    .q   (ks)
  );

  assign deb_done = (deb_cnt >= DEB_LAST);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ks) state_nxt = DEB_DN;
      DEB_DN:  if (!ks) state_nxt = IDLE;
               else if (deb_done) state_nxt = HELD;
      HELD:    if (!ks) state_nxt = DEB_UP;
      DEB_UP:  if (ks) state_nxt = HELD;
               else if (deb_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    oKEY      = (state == HELD) || (state == DEB_UP);
    release_d = (state == DEB_UP) && !ks && deb_done;
    long_d    = (state == HELD) && (hold_cnt == LONG_PRE) && (hold_cnt != LONG_MAX);
    press_d   = ((state == DEB_DN) && ks && deb_done) || rep_fire;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      deb_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      if ((state == DEB_DN) || (state == DEB_UP)) deb_cnt <= deb_cnt + CW'(1);
      else                                        deb_cnt <= '0;

      // Hold time survives release bounces; only a fresh press restarts it.
      if ((state == DEB_DN) && (state_nxt == HELD))
        hold_cnt <= '0;
      else if ((state == HELD) && (hold_cnt != LONG_MAX))
        hold_cnt <= hold_cnt + CW'(1);
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
  logic [CW-1:0] rep_cnt;
  logic          rep_run;

  assign rep_run  = (state == HELD) && (hold_cnt == LONG_MAX);
  assign rep_fire = rep_run && (rep_cnt == REP_LAST);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)         rep_cnt <= '0;
    else if (long_d)  rep_cnt <= '0;
    else if (rep_run) rep_cnt <= rep_fire ? '0 : rep_cnt + CW'(1);
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oPRESS   <= 1'b0;
      oRELEASE <= 1'b0;
      oLONG    <= 1'b0;
      oCNT     <= '0;
    end else begin
      oPRESS   <= press_d;
      oRELEASE <= release_d;
      oLONG    <= long_d;
      if (press_d) oCNT <= oCNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_key_reader.sv
// tb/tb_key_reader.sv - self-checking bench for key_reader with a cycle-level reference model
module tb_key_reader;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic       o_key, o_press, o_release, o_long;
  logic [7:0] o_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mark;
  int press_q[$];
  int long_q[$];
  int rel_q[$];

  // reference model state
  logic       m_s1, m_s2, m_level;
  int         m_run, m_hold;
`ifdef KEY_AUTOREPEAT_EN
  int         m_rep;
`endif
  logic [7:0] m_cnt;
  logic       e_press, e_rel, e_long;

  key_reader #(
    .DEB_CYCLES    (DEB),
    .LONG_CYCLES   (LNG),
    .REPEAT_CYCLES (REP)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iKEY     (key),
    .oKEY     (o_key),
    .oPRESS   (o_press),
    .oRELEASE (o_release),
    .oLONG    (o_long),
    .oCNT     (o_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Level flips once the synchronized key has disagreed with it for DEB consecutive samples.
  task automatic model_step();
    logic k;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_hold = 0; m_cnt = 0;
`ifdef KEY_AUTOREPEAT_EN
      m_rep = 0;
`endif
      e_press = 0; e_rel = 0; e_long = 0;
      return;
    end
    k = m_s2;
    m_s2 = m_s1;
    m_s1 = key;
    e_press = 0; e_rel = 0; e_long = 0;
    if (m_level && m_run == 0) begin
      if (m_hold < LNG) begin
        m_hold++;
        if (m_hold == LNG) begin
          e_long = 1;
`ifdef KEY_AUTOREPEAT_EN
          m_rep = 0;
`endif
        end
      end
`ifdef KEY_AUTOREPEAT_EN
      else begin
        m_rep++;
        if (m_rep == REP) begin
          m_rep = 0;
          e_press = 1;
          m_cnt++;
        end
      end
`endif
    end
    if (k != m_level) m_run++;
    else m_run = 0;
    if (m_run == DEB) begin
      m_run = 0;
      m_level = k;
      if (k) begin
        e_press = 1;
        m_cnt++;
        m_hold = 0;
      end else begin
        e_rel = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      chk("model_compare{key,press,release,long,cnt}",
          int'({o_key, o_press, o_release, o_long, o_cnt}),
          int'({m_level, e_press, e_rel, e_long, m_cnt}));
      if (o_press)   press_q.push_back(cyc);
      if (o_long)    long_q.push_back(cyc);
      if (o_release) rel_q.push_back(cyc);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key = 1'b0;
    wait_n(2);
    rst = 1'b0;
    press_q.delete();
    long_q.delete();
    rel_q.delete();
    wait_n(2);
  endtask

  initial begin
    wait_n(3);
    chk("reset_outputs", int'({o_key, o_press, o_release, o_long, o_cnt}), 0);
    rst = 1'b0;
    wait_n(2);

    // clean press
    do_reset();
    @(negedge clk);
    mark = cyc;
    key = 1'b1;
    wait_n(8);
    chk("clean_okey_high", int'(o_key), 1);
    chk("clean_cnt", int'(o_cnt), 1);
    wait_n(2);
    key = 1'b0;
    wait_n(10);
    chk("clean_press_count", press_q.size(), 1);
    chk("clean_press_latency", press_q[0] - mark, 6);
    chk("clean_release_latency", rel_q[0] - (mark + 10), 6);
    chk("clean_okey_low", int'(o_key), 0);

    // bounce rejection
    do_reset();
    @(negedge clk);
    key = 1'b1; wait_n(2);
    key = 1'b0; wait_n(2);
    key = 1'b1; wait_n(2);
    key = 1'b0; wait_n(12);
    chk("bounce_press_count", press_q.size(), 0);
    chk("bounce_okey", int'(o_key), 0);
    chk("bounce_cnt", int'(o_cnt), 0);

    // long press
    do_reset();
    @(negedge clk);
    mark = cyc;
    key = 1'b1;
    wait_n(30);
    key = 1'b0;
    wait_n(12);
    chk("long_press_count", press_q.size(), 1);
    chk("long_pulse_count", long_q.size(), 1);
    chk("long_after_press", long_q[0] - press_q[0], 20);
    chk("long_release_latency", rel_q[0] - (mark + 30), 6);
    chk("long_cnt", int'(o_cnt), 1);

    // held 45 cycles: repeats only when auto-repeat is built in
    do_reset();
    @(negedge clk);
    mark = cyc;
    key = 1'b1;
    wait_n(45);
    key = 1'b0;
    wait_n(12);
    chk("hold45_first_press", press_q[0] - mark, 6);
`ifdef KEY_AUTOREPEAT_EN
    chk("repeat_press_count", press_q.size(), 3);
    chk("repeat_first", press_q[1] - long_q[0], 8);
    chk("repeat_second", press_q[2] - long_q[0], 16);
    chk("repeat_cnt", int'(o_cnt), 3);
`else
    chk("norepeat_press_count", press_q.size(), 1);
    chk("norepeat_cnt", int'(o_cnt), 1);
`endif

    // counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      key = 1'b1; wait_n(8);
      key = 1'b0; wait_n(8);
      if (i == 254) chk("wrap_cnt_255", int'(o_cnt), 255);
    end
    chk("wrap_cnt_0", int'(o_cnt), 0);
    chk("wrap_press_count", press_q.size(), 256);

    // reset while held
    do_reset();
    @(negedge clk);
    key = 1'b1;
    wait_n(10);
    chk("midreset_pre_okey", int'(o_key), 1);
    #5;
    rst = 1'b1;
    #1;
    chk("midreset_async_zero", int'({o_key, o_press, o_release, o_long, o_cnt}), 0);
    wait_n(2);
    rst = 1'b0;
    mark = cyc;
    press_q.delete();
    rel_q.delete();
    wait_n(8);
    chk("midreset_press_count", press_q.size(), 1);
    chk("midreset_press_latency", press_q[0] - mark, 6);
    chk("midreset_cnt", int'(o_cnt), 1);
    chk("midreset_no_release", rel_q.size(), 0);
    key = 1'b0;
    wait_n(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_reader.md
KEY_READER -- requirements
Module: key_reader

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, debounce stability window in clock cycles (20 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, hold time in cycles for long-press detection (1 s).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000000, auto-repeat period in cycles; used only with KEY_AUTOREPEAT_EN.
REQ-004 SHALL have port iCLK  input  1  single system clock, rising edge.
REQ-005 SHALL have port iRST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port iKEY  input  1  raw pushbutton, asynchronous to iCLK, active-high, bouncing.
REQ-007 SHALL have port oKEY  output  1  debounced key level.
REQ-008 SHALL have port oPRESS  output  1  one-cycle pulse per accepted press (and per repeat).
REQ-009 SHALL have port oRELEASE  output  1  one-cycle pulse per accepted release.
REQ-010 SHALL have port oLONG  output  1  one-cycle pulse when a press has been held LONG_CYCLES.
REQ-011 SHALL have port oCNT  output  8  press counter, LED-drivable.

Function
REQ-012 SHALL pass iKEY through a 2-flop synchronizer; only the synchronized bit (ks) is used downstream.
REQ-013 SHALL implement FSM states IDLE, DEB_DN, HELD, DEB_UP.
REQ-014 IDLE: ks=1 -> DEB_DN with debounce counter cleared; otherwise stay.
REQ-015 DEB_DN: ks=0 -> IDLE (bounce rejected, no pulse); ks=1 for DEB_CYCLES consecutive cycles -> HELD, asserting oPRESS for exactly one cycle and setting oKEY=1 on that transition.
REQ-016 HELD: ks=0 -> DEB_UP with debounce counter cleared; hold timer increments every cycle in HELD.
REQ-017 DEB_UP: ks=1 -> HELD (hold timer not cleared); ks=0 for DEB_CYCLES consecutive cycles -> IDLE, asserting oRELEASE for one cycle and clearing oKEY.
REQ-018 Latency iKEY clean edge -> oKEY/oPRESS/oRELEASE SHALL be exactly 2 + DEB_CYCLES cycles.
REQ-019 oLONG SHALL pulse once, on the cycle the hold timer reaches LONG_CYCLES; never more than once per press; hold timer saturates, cleared on entry to HELD from DEB_DN.
REQ-020 oCNT SHALL increment by 1 on every oPRESS cycle, wrapping 255 -> 0; no other event changes it.
REQ-021 Counters SHALL be sized $clog2 of the largest parameter + 1; no overflow at default values.
REQ-022 At most one of oPRESS/oRELEASE SHALL be high in any cycle.

Reset
REQ-023 iRST high SHALL immediately force FSM=IDLE, synchronizer flops, all counters, oKEY, oPRESS, oRELEASE, oLONG to 0 and oCNT to 8'h00, regardless of clock.
REQ-024 Reset mid-press SHALL produce no oRELEASE; a key still held after reset deassertion SHALL be treated as a new press after 2 + DEB_CYCLES cycles.

Configuration
REQ-025 Macro KEY_AUTOREPEAT_EN defined: in HELD after oLONG, oPRESS SHALL pulse (and oCNT increment) every REPEAT_CYCLES cycles until leaving HELD; the first repeat occurs REPEAT_CYCLES after the oLONG cycle.
REQ-026 Macro KEY_AUTOREPEAT_EN undefined: no repeat logic or counter synthesized; exactly one oPRESS per physical press.

Structure
REQ-027 Package key_pkg SHALL hold the FSM state typedef (2-bit enum) and the oCNT width constant (8).
REQ-028 Sub-module key_sync SHALL implement the 2-flop synchronizer with asynchronous active-high reset; all other logic in key_reader.

Verification (bench params DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, 20 ns clock)
REQ-029 Clean press: iKEY 0->1 held 10 cycles -> oPRESS one pulse 6 cycles after the edge, oKEY=1, oCNT=1.
REQ-030 Bounce: iKEY toggled 1,0,1,0 every 2 cycles, then held 0 -> no oPRESS, oKEY stays 0, oCNT=0.
REQ-031 Long press: iKEY held 30 cycles then released -> oPRESS once, oLONG once 20 cycles later, oRELEASE 6 cycles after release; no repeat without macro.
REQ-032 Auto-repeat (macro defined): iKEY held 45 cycles -> oPRESS at press, then at oLONG+8 and oLONG+16; oCNT=3.
REQ-033 Wrap: 256 clean presses -> oCNT returns to 8'h00 with no glitch on the 255->0 transition.
REQ-034 Reset mid-press: iRST asserted in HELD -> all outputs 0 same cycle, no oRELEASE; iKEY still high -> oPRESS 6 cycles after iRST deasserts, oCNT=1.
